// File: rtl/axi_sram_responder.sv
// axi_sram_responder
//   AXI4 slave that terminates the remapped memory window with an on-chip
//   64-bit SRAM. The read and write engines are independent, and each one
//   holds a single burst. Supported bursts are INCR, FIXED and WRAP. A beat
//   that falls outside [BASE, BASE+DEPTH*8) returns SLVERR.
// Ports
//   clock, reset        : single clock; synchronous active-high reset
//   s_axi_aw*/w*/b*     : write address, write data and write response channels
//   s_axi_ar*/r*        : read address and read data channels
//   awlock/cache/prot/qos and the ar equivalents are accepted but ignored.
module axi_sram_responder #(
   parameter logic [31:0] BASE  = 32'h1000_0000,
   parameter int          DEPTH = 1024
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [7:0]  s_axi_awid,
   input  logic [31:0] s_axi_awaddr,
   input  logic [7:0]  s_axi_awlen,
   input  logic [2:0]  s_axi_awsize,
   input  logic [1:0]  s_axi_awburst,
   input  logic        s_axi_awlock,
   input  logic [3:0]  s_axi_awcache,
   input  logic [2:0]  s_axi_awprot,
   input  logic [3:0]  s_axi_awqos,
   input  logic        s_axi_awvalid,
   output logic        s_axi_awready,
   input  logic [63:0] s_axi_wdata,
   input  logic [7:0]  s_axi_wstrb,
   input  logic        s_axi_wlast,
   input  logic        s_axi_wvalid,
   output logic        s_axi_wready,
   output logic [7:0]  s_axi_bid,
   output logic [1:0]  s_axi_bresp,
   output logic        s_axi_bvalid,
   input  logic        s_axi_bready,
   input  logic [7:0]  s_axi_arid,
   input  logic [31:0] s_axi_araddr,
   input  logic [7:0]  s_axi_arlen,
   input  logic [2:0]  s_axi_arsize,
   input  logic [1:0]  s_axi_arburst,
   input  logic        s_axi_arlock,
   input  logic [3:0]  s_axi_arcache,
   input  logic [2:0]  s_axi_arprot,
   input  logic [3:0]  s_axi_arqos,
   input  logic        s_axi_arvalid,
   output logic        s_axi_arready,
   output logic [7:0]  s_axi_rid,
   output logic [63:0] s_axi_rdata,
   output logic [1:0]  s_axi_rresp,
   output logic        s_axi_rlast,
   output logic        s_axi_rvalid,
   input  logic        s_axi_rready
);
   localparam int          AW       = $clog2(DEPTH);
   // BASE is aligned to the window size, so a masked compare is enough
   // to decide whether an address is inside the window.
   localparam logic [31:0] WIN_MASK = ~(32'(DEPTH) * 32'd8 - 32'd1);

   typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
   typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} r_state_t;

   function automatic logic in_win(input logic [31:0] a);
      return (a & WIN_MASK) == BASE;
   endfunction

   function automatic logic [31:0] next_addr(input logic [31:0] a, input logic [2:0] size,
                                             input logic [7:0] len, input logic [1:0] burst);
      logic [31:0] inc;
      logic [31:0] mask;
      logic [31:0] res;
      inc  = 32'd1 << size;
      mask = (({24'd0, len} + 32'd1) << size) - 32'd1;
      res  = a + inc;
      if (burst == 2'b00)
         res = a;
      else if (burst == 2'b10 && (len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15))
         res = (a & ~mask) | ((a + inc) & mask);
      return res;
   endfunction

   logic unused_sideband;
   assign unused_sideband = ^{s_axi_awlock, s_axi_awcache, s_axi_awprot, s_axi_awqos,
                              s_axi_arlock, s_axi_arcache, s_axi_arprot, s_axi_arqos};

   // ---------------- write engine ----------------
   w_state_t    w_state_q, w_state_d;
   logic [7:0]  aw_id_q, aw_id_d, aw_len_q, aw_len_d, w_cnt_q, w_cnt_d;
   logic [31:0] aw_addr_q, aw_addr_d;
   logic [2:0]  aw_size_q, aw_size_d;
   logic [1:0]  aw_burst_q, aw_burst_d;
   logic        w_err_q, w_err_d;
   logic        mem_we;

   always_comb begin
      w_state_d  = w_state_q;
      aw_id_d    = aw_id_q;
      aw_addr_d  = aw_addr_q;
      aw_len_d   = aw_len_q;
      aw_size_d  = aw_size_q;
      aw_burst_d = aw_burst_q;
      w_cnt_d    = w_cnt_q;
      w_err_d    = w_err_q;
      mem_we     = 1'b0;
      case (w_state_q)
         W_IDLE: if (s_axi_awvalid) begin
            aw_id_d    = s_axi_awid;
            aw_addr_d  = s_axi_awaddr;
            aw_len_d   = s_axi_awlen;
            aw_size_d  = s_axi_awsize;
            aw_burst_d = s_axi_awburst;
            w_cnt_d    = 8'd0;
            w_err_d    = 1'b0;
            w_state_d  = W_DATA;
         end
         W_DATA: if (s_axi_wvalid) begin
            if (in_win(aw_addr_q)) mem_we = 1'b1;
            else                   w_err_d = 1'b1;
            aw_addr_d = next_addr(aw_addr_q, aw_size_q, aw_len_q, aw_burst_q);
            w_cnt_d   = w_cnt_q + 8'd1;
            // An early wlast also closes the burst.
            if (s_axi_wlast || w_cnt_q == aw_len_q) w_state_d = W_RESP;
         end
         W_RESP: if (s_axi_bready) w_state_d = W_IDLE;
         default: w_state_d = W_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         w_state_q  <= W_IDLE;
         aw_id_q    <= '0;
         aw_addr_q  <= '0;
         aw_len_q   <= '0;
         aw_size_q  <= '0;
         aw_burst_q <= '0;
         w_cnt_q    <= '0;
         w_err_q    <= 1'b0;
      end else begin
         w_state_q  <= w_state_d;
         aw_id_q    <= aw_id_d;
         aw_addr_q  <= aw_addr_d;
         aw_len_q   <= aw_len_d;
         aw_size_q  <= aw_size_d;
         aw_burst_q <= aw_burst_d;
         w_cnt_q    <= w_cnt_d;
         w_err_q    <= w_err_d;
      end
   end

   assign s_axi_awready = (w_state_q == W_IDLE);
   assign s_axi_wready  = (w_state_q == W_DATA);
   assign s_axi_bvalid  = (w_state_q == W_RESP);
   assign s_axi_bid     = aw_id_q;
   assign s_axi_bresp   = w_err_q ? 2'b10 : 2'b00;

   // ---------------- read engine ----------------
   r_state_t    r_state_q, r_state_d;
   logic [7:0]  ar_id_q, ar_id_d, ar_len_q, ar_len_d, r_cnt_q, r_cnt_d;
   logic [31:0] ar_addr_q, ar_addr_d;
   logic [2:0]  ar_size_q, ar_size_d;
   logic [1:0]  ar_burst_q, ar_burst_d, rresp_q, rresp_d;

   always_comb begin
      r_state_d  = r_state_q;
      ar_id_d    = ar_id_q;
      ar_addr_d  = ar_addr_q;
      ar_len_d   = ar_len_q;
      ar_size_d  = ar_size_q;
      ar_burst_d = ar_burst_q;
      r_cnt_d    = r_cnt_q;
      rresp_d    = rresp_q;
      case (r_state_q)
         R_IDLE: if (s_axi_arvalid) begin
            ar_id_d    = s_axi_arid;
            ar_addr_d  = s_axi_araddr;
            ar_len_d   = s_axi_arlen;
            ar_size_d  = s_axi_arsize;
            ar_burst_d = s_axi_arburst;
            r_cnt_d    = 8'd0;
            r_state_d  = R_FETCH;
         end
         R_FETCH: begin
            rresp_d   = in_win(ar_addr_q) ? 2'b00 : 2'b10;
            r_state_d = R_DATA;
         end
         R_DATA: if (s_axi_rready) begin
            if (r_cnt_q == ar_len_q) begin
               r_state_d = R_IDLE;
            end else begin
               ar_addr_d = next_addr(ar_addr_q, ar_size_q, ar_len_q, ar_burst_q);
               r_cnt_d   = r_cnt_q + 8'd1;
               r_state_d = R_FETCH;
            end
         end
         default: r_state_d = R_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state_q  <= R_IDLE;
         ar_id_q    <= '0;
         ar_addr_q  <= '0;
         ar_len_q   <= '0;
         ar_size_q  <= '0;
         ar_burst_q <= '0;
         r_cnt_q    <= '0;
         rresp_q    <= '0;
      end else begin
         r_state_q  <= r_state_d;
         ar_id_q    <= ar_id_d;
         ar_addr_q  <= ar_addr_d;
         ar_len_q   <= ar_len_d;
         ar_size_q  <= ar_size_d;
         ar_burst_q <= ar_burst_d;
         r_cnt_q    <= r_cnt_d;
         rresp_q    <= rresp_d;
      end
   end

   // ---------------- SRAM ----------------
   // Nonblocking write and read on the same edge: a same-word read sees the old data.
   logic [63:0] mem [DEPTH];
   logic [63:0] sram_dout;
   logic [AW-1:0] w_idx, r_idx;
   assign w_idx = aw_addr_q[AW+2:3];
   assign r_idx = ar_addr_q[AW+2:3];

   always_ff @(posedge clock) begin
      if (mem_we && !reset)
         for (int b = 0; b < 8; b++)
            if (s_axi_wstrb[b]) mem[w_idx][8*b +: 8] <= s_axi_wdata[8*b +: 8];
      if (reset)
         sram_dout <= '0;
      else if (r_state_q == R_FETCH)
         sram_dout <= in_win(ar_addr_q) ? mem[r_idx] : 64'd0;
   end

   assign s_axi_arready = (r_state_q == R_IDLE);
   assign s_axi_rvalid  = (r_state_q == R_DATA);
   assign s_axi_rlast   = (r_state_q == R_DATA) && (r_cnt_q == ar_len_q);
   assign s_axi_rid     = ar_id_q;
   assign s_axi_rdata   = sram_dout;
   assign s_axi_rresp   = rresp_q;
endmodule

// File: tb/tb_axi_sram_responder.sv
// Directed testbench for axi_sram_responder. Inputs are driven 1 ns after
// the rising edge, and outputs are sampled on the falling edge.
module tb_axi_sram_responder;
   localparam logic [31:0] BASE = 32'h1000_0000;

   logic clock = 1'b0, reset = 1'b1;
   always #5 clock = ~clock;

   logic [7:0]  s_axi_awid = '0, s_axi_awlen = '0, s_axi_arid = '0, s_axi_arlen = '0;
   logic [31:0] s_axi_awaddr = '0, s_axi_araddr = '0;
   logic [2:0]  s_axi_awsize = 3'd3, s_axi_arsize = 3'd3, s_axi_awprot = '0, s_axi_arprot = '0;
   logic [1:0]  s_axi_awburst = 2'b01, s_axi_arburst = 2'b01;
   logic        s_axi_awlock = 1'b0, s_axi_arlock = 1'b0;
   logic [3:0]  s_axi_awcache = '0, s_axi_awqos = '0, s_axi_arcache = '0, s_axi_arqos = '0;
   logic        s_axi_awvalid = 1'b0, s_axi_wvalid = 1'b0, s_axi_wlast = 1'b0, s_axi_bready = 1'b0;
   logic        s_axi_arvalid = 1'b0, s_axi_rready = 1'b0;
   logic [63:0] s_axi_wdata = '0;
   logic [7:0]  s_axi_wstrb = '0;
   logic        s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_arready, s_axi_rvalid, s_axi_rlast;
   logic [7:0]  s_axi_bid, s_axi_rid;
   logic [1:0]  s_axi_bresp, s_axi_rresp;
   logic [63:0] s_axi_rdata;

   axi_sram_responder #(.BASE(BASE), .DEPTH(1024)) dut (
      .clock(clock), .reset(reset),
      .s_axi_awid(s_axi_awid), .s_axi_awaddr(s_axi_awaddr), .s_axi_awlen(s_axi_awlen),
      .s_axi_awsize(s_axi_awsize), .s_axi_awburst(s_axi_awburst), .s_axi_awlock(s_axi_awlock),
      .s_axi_awcache(s_axi_awcache), .s_axi_awprot(s_axi_awprot), .s_axi_awqos(s_axi_awqos),
      .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
      .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
      .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
      .s_axi_bid(s_axi_bid), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
      .s_axi_bready(s_axi_bready),
      .s_axi_arid(s_axi_arid), .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen),
      .s_axi_arsize(s_axi_arsize), .s_axi_arburst(s_axi_arburst), .s_axi_arlock(s_axi_arlock),
      .s_axi_arcache(s_axi_arcache), .s_axi_arprot(s_axi_arprot), .s_axi_arqos(s_axi_arqos),
      .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
      .s_axi_rid(s_axi_rid), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
      .s_axi_rlast(s_axi_rlast), .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready)
   );

   int checks = 0, errors = 0, cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   logic [63:0] wbuf [16];
   logic [63:0] rbuf [16];
   logic [1:0]  rresp_c [16];
   logic        rlast_c [16];
   logic [7:0]  rid_c [16];
   int          rcyc [16];
   int          aw_cyc, b_cyc, ar_cyc;
   logic [7:0]  bid_c;
   logic [1:0]  bresp_c;
   bit          w_to, r_to, r_unstable;

   // Stimulus: one write burst (full size) followed by its B handshake.
   task automatic write_burst(input logic [7:0] id, input logic [31:0] addr, input logic [7:0] len,
                              input logic [1:0] burst, input logic [7:0] strb, input bit gap);
      int n;
      w_to = 0;
      s_axi_awid = id; s_axi_awaddr = addr; s_axi_awlen = len; s_axi_awsize = 3'd3;
      s_axi_awburst = burst; s_axi_awvalid = 1'b1; s_axi_bready = 1'b1;
      n = 0; @(negedge clock);
      while (!s_axi_awready && n < 50) begin n++; @(negedge clock); end
      if (!s_axi_awready) w_to = 1;
      aw_cyc = cyc;
      @(posedge clock); #1 s_axi_awvalid = 1'b0;
      for (int b = 0; b <= int'(len); b++) begin
         if (gap) begin @(posedge clock); #1; end
         s_axi_wdata = wbuf[b]; s_axi_wstrb = strb; s_axi_wlast = (b == int'(len)); s_axi_wvalid = 1'b1;
         n = 0; @(negedge clock);
         while (!s_axi_wready && n < 50) begin n++; @(negedge clock); end
         if (!s_axi_wready) w_to = 1;
         @(posedge clock); #1 s_axi_wvalid = 1'b0; s_axi_wlast = 1'b0;
      end
      n = 0; @(negedge clock);
      while (!s_axi_bvalid && n < 50) begin n++; @(negedge clock); end
      if (!s_axi_bvalid) w_to = 1;
      b_cyc = cyc; bid_c = s_axi_bid; bresp_c = s_axi_bresp;
      @(posedge clock); #1 s_axi_bready = 1'b0;
   endtask

   // Stimulus: one read burst, optionally holding rready low on one beat.
   task automatic read_burst(input logic [7:0] id, input logic [31:0] addr, input logic [7:0] len,
                             input logic [1:0] burst, input int stall_beat, input int stall_n);
      int n;
      r_to = 0; r_unstable = 0;
      s_axi_arid = id; s_axi_araddr = addr; s_axi_arlen = len; s_axi_arsize = 3'd3;
      s_axi_arburst = burst; s_axi_arvalid = 1'b1; s_axi_rready = 1'b1;
      n = 0; @(negedge clock);
      while (!s_axi_arready && n < 50) begin n++; @(negedge clock); end
      if (!s_axi_arready) r_to = 1;
      ar_cyc = cyc;
      @(posedge clock); #1 s_axi_arvalid = 1'b0;
      for (int b = 0; b <= int'(len); b++) begin
         n = 0; @(negedge clock);
         while (!s_axi_rvalid && n < 50) begin n++; @(negedge clock); end
         if (!s_axi_rvalid) r_to = 1;
         rbuf[b] = s_axi_rdata; rresp_c[b] = s_axi_rresp; rlast_c[b] = s_axi_rlast;
         rid_c[b] = s_axi_rid; rcyc[b] = cyc;
         if (b == stall_beat) begin
            s_axi_rready = 1'b0;
            repeat (stall_n) begin
               @(negedge clock);
               if (s_axi_rvalid !== 1'b1 || s_axi_rdata !== rbuf[b] || s_axi_rid !== rid_c[b] ||
                   s_axi_rlast !== rlast_c[b] || s_axi_rresp !== rresp_c[b]) r_unstable = 1;
            end
            s_axi_rready = 1'b1;
         end
         @(posedge clock); #1;
      end
      s_axi_rready = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(posedge clock);
      @(negedge clock);
      checks++; if ({s_axi_awready, s_axi_arready, s_axi_wready, s_axi_bvalid, s_axi_rvalid} !== 5'b11000) begin
         errors++; $display("FAIL reset_handshake got %b want 11000",
            {s_axi_awready, s_axi_arready, s_axi_wready, s_axi_bvalid, s_axi_rvalid}); end
      checks++; if ({s_axi_bid, s_axi_bresp, s_axi_rid, s_axi_rresp, s_axi_rlast} !== 21'd0 || s_axi_rdata !== 64'd0) begin
         errors++; $display("FAIL reset_fields got bid=%h rid=%h rdata=%h want 0", s_axi_bid, s_axi_rid, s_axi_rdata); end
      @(posedge clock); #1 reset = 1'b0;
      // Open a write and a read, then reset in the middle of both.
      s_axi_awid = 8'h05; s_axi_awaddr = BASE + 32'h40; s_axi_awlen = 8'd3; s_axi_awburst = 2'b01; s_axi_awvalid = 1'b1;
      s_axi_arid = 8'h06; s_axi_araddr = BASE; s_axi_arlen = 8'd3; s_axi_arburst = 2'b01; s_axi_arvalid = 1'b1;
      s_axi_rready = 1'b0;
      @(posedge clock); #1 s_axi_awvalid = 1'b0; s_axi_arvalid = 1'b0;
      s_axi_wdata = 64'hDEAD_0000_0000_BEEF; s_axi_wstrb = 8'hFF; s_axi_wvalid = 1'b1;
      @(posedge clock); #1 s_axi_wvalid = 1'b0;
      @(negedge clock);
      checks++; if (s_axi_rvalid !== 1'b1 || s_axi_wready !== 1'b1) begin
         errors++; $display("FAIL midburst_state got rvalid=%b wready=%b want 1 1", s_axi_rvalid, s_axi_wready); end
      reset = 1'b1;
      repeat (3) @(posedge clock);
      @(negedge clock);
      checks++; if ({s_axi_awready, s_axi_arready, s_axi_wready, s_axi_bvalid, s_axi_rvalid, s_axi_rlast} !== 6'b110000 ||
                    s_axi_rdata !== 64'd0 || s_axi_bid !== 8'd0 || s_axi_rid !== 8'd0) begin
         errors++; $display("FAIL midburst_reset got aw=%b ar=%b w=%b b=%b r=%b rdata=%h want reset values",
            s_axi_awready, s_axi_arready, s_axi_wready, s_axi_bvalid, s_axi_rvalid, s_axi_rdata); end
      s_axi_awid = 8'h07; s_axi_awaddr = BASE + 32'h48; s_axi_awlen = 8'd0; s_axi_awvalid = 1'b1;
      @(posedge clock); #1 reset = 1'b0;
      @(negedge clock);
      checks++; if (s_axi_awready !== 1'b1) begin
         errors++; $display("FAIL aw_after_reset got awready=%b want 1", s_axi_awready); end
      @(posedge clock); #1 s_axi_awvalid = 1'b0;
      s_axi_wdata = 64'h77; s_axi_wlast = 1'b1; s_axi_wvalid = 1'b1;
      @(posedge clock); #1 s_axi_wvalid = 1'b0; s_axi_wlast = 1'b0; s_axi_bready = 1'b1;
      @(negedge clock);
      checks++; if (s_axi_bvalid !== 1'b1 || s_axi_bid !== 8'h07 || s_axi_bresp !== 2'b00) begin
         errors++; $display("FAIL post_reset_b got bvalid=%b bid=%h bresp=%b want 1 07 00", s_axi_bvalid, s_axi_bid, s_axi_bresp); end
      @(posedge clock); #1 s_axi_bready = 1'b0;
      read_burst(8'h0C, BASE + 32'h40, 8'd1, 2'b01, -1, 0);
      checks++; if (r_to || rbuf[0] !== 64'hDEAD_0000_0000_BEEF || rbuf[1] !== 64'h77) begin
         errors++; $display("FAIL persist_after_reset got %h %h want dead00000000beef 77", rbuf[0], rbuf[1]); end
   endtask

   task automatic test_incr();
      wbuf[0] = 64'h11; wbuf[1] = 64'h22; wbuf[2] = 64'h33; wbuf[3] = 64'h44;
      write_burst(8'h3A, BASE, 8'd3, 2'b01, 8'hFF, 1'b0);
      checks++; if (w_to || bresp_c !== 2'b00 || bid_c !== 8'h3A) begin
         errors++; $display("FAIL incr_write_b got bid=%h bresp=%b to=%0d want 3a 00 0", bid_c, bresp_c, w_to); end
      checks++; if (b_cyc - aw_cyc !== 5) begin
         errors++; $display("FAIL incr_write_lat got %0d want 5", b_cyc - aw_cyc); end
      read_burst(8'h5C, BASE, 8'd3, 2'b01, -1, 0);
      for (int b = 0; b < 4; b++) begin
         checks++;
         if (r_to || rbuf[b] !== 64'(b + 1) * 64'h11 || rresp_c[b] !== 2'b00 || rid_c[b] !== 8'h5C ||
             rlast_c[b] !== (b == 3) || rcyc[b] - ar_cyc !== 2 + 2 * b) begin
            errors++; $display("FAIL incr_read_beat%0d got data=%h resp=%b id=%h last=%b lat=%0d want %h 00 5c %b %0d",
               b, rbuf[b], rresp_c[b], rid_c[b], rlast_c[b], rcyc[b] - ar_cyc, 64'(b + 1) * 64'h11, b == 3, 2 + 2 * b);
         end
      end
   endtask

   task automatic test_wrap();
      logic [63:0] exp [4];
      exp[0] = 64'h44; exp[1] = 64'h11; exp[2] = 64'h22; exp[3] = 64'h33;
      read_burst(8'h77, BASE + 32'h18, 8'd3, 2'b10, -1, 0);
      for (int b = 0; b < 4; b++) begin
         checks++; if (r_to || rbuf[b] !== exp[b] || rlast_c[b] !== (b == 3)) begin
            errors++; $display("FAIL wrap_beat%0d got %h last=%b want %h", b, rbuf[b], rlast_c[b], exp[b]); end
      end
   endtask

   task automatic test_out_of_window();
      wbuf[0] = 64'hAAAA_AAAA_AAAA_AAAA; wbuf[1] = 64'hBBBB_BBBB_BBBB_BBBB;
      write_burst(8'h81, BASE + 32'h1FF8, 8'd1, 2'b01, 8'hFF, 1'b0);
      checks++; if (w_to || bresp_c !== 2'b10 || bid_c !== 8'h81) begin
         errors++; $display("FAIL oow_write_b got bid=%h bresp=%b want 81 10", bid_c, bresp_c); end
      read_burst(8'h82, BASE + 32'h1FF8, 8'd1, 2'b01, -1, 0);
      checks++; if (r_to || rbuf[0] !== 64'hAAAA_AAAA_AAAA_AAAA || rresp_c[0] !== 2'b00) begin
         errors++; $display("FAIL oow_last_word got %h resp=%b want aaaaaaaaaaaaaaaa 00", rbuf[0], rresp_c[0]); end
      checks++; if (rbuf[1] !== 64'd0 || rresp_c[1] !== 2'b10 || rlast_c[1] !== 1'b1) begin
         errors++; $display("FAIL oow_read got %h resp=%b last=%b want 0 10 1", rbuf[1], rresp_c[1], rlast_c[1]); end
   endtask

   task automatic test_backpressure();
      wbuf[0] = 64'h0123_4567_89AB_CDEF; wbuf[1] = 64'hFEDC_BA98_7654_3210;
      write_burst(8'h10, BASE + 32'h20, 8'd1, 2'b01, 8'hFF, 1'b0);
      wbuf[0] = 64'h1111_1111_2222_2222; wbuf[1] = 64'h3333_3333_4444_4444;
      write_burst(8'h11, BASE + 32'h20, 8'd1, 2'b01, 8'h0F, 1'b1);
      checks++; if (w_to || bresp_c !== 2'b00 || bid_c !== 8'h11) begin
         errors++; $display("FAIL strobe_write_b got bid=%h bresp=%b want 11 00", bid_c, bresp_c); end
      read_burst(8'h99, BASE + 32'h20, 8'd1, 2'b01, 0, 5);
      checks++; if (r_to || rbuf[0] !== 64'h0123_4567_2222_2222 || rbuf[1] !== 64'hFEDC_BA98_4444_4444) begin
         errors++; $display("FAIL strobe_merge got %h %h want 0123456722222222 fedcba9844444444", rbuf[0], rbuf[1]); end
      checks++; if (r_unstable || rid_c[0] !== 8'h99) begin
         errors++; $display("FAIL stall_stable got unstable=%0d rid=%h want 0 99", r_unstable, rid_c[0]); end
      checks++; if (rcyc[1] - ar_cyc !== 9) begin
         errors++; $display("FAIL stall_timing got %0d want 9", rcyc[1] - ar_cyc); end
   endtask

   task automatic test_concurrency();
      wbuf[0] = 64'hCAFE_F00D_1234_5678;
      write_burst(8'h20, BASE + 32'h30, 8'd0, 2'b01, 8'hFF, 1'b0);
      wbuf[0] = 64'h0BAD_BEEF_0000_0001;
      fork
         write_burst(8'h21, BASE + 32'h30, 8'd0, 2'b01, 8'hFF, 1'b0);
         read_burst(8'h42, BASE + 32'h30, 8'd0, 2'b01, -1, 0);
      join
      checks++; if (aw_cyc !== ar_cyc) begin
         errors++; $display("FAIL conc_same_cycle got aw=%0d ar=%0d want equal", aw_cyc, ar_cyc); end
      checks++; if (r_to || rbuf[0] !== 64'hCAFE_F00D_1234_5678 || rid_c[0] !== 8'h42) begin
         errors++; $display("FAIL conc_read_first got %h id=%h want cafef00d12345678 42", rbuf[0], rid_c[0]); end
      checks++; if (w_to || bid_c !== 8'h21 || bresp_c !== 2'b00) begin
         errors++; $display("FAIL conc_write_b got bid=%h bresp=%b want 21 00", bid_c, bresp_c); end
      read_burst(8'h43, BASE + 32'h30, 8'd0, 2'b01, -1, 0);
      checks++; if (r_to || rbuf[0] !== 64'h0BAD_BEEF_0000_0001) begin
         errors++; $display("FAIL conc_new_data got %h want 0badbeef00000001", rbuf[0]); end
   endtask

   initial begin
      test_reset();
      test_incr();
      test_wrap();
      test_out_of_window();
      test_backpressure();
      test_concurrency();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/axi_sram_responder.md
# axi_sram_responder

AXI4 slave endpoint that terminates the memory-side master port of the FPGA address remap path (remapped window 0x1xxx_xxxx) with an on-chip dual-port SRAM. Independent read and write engines accept one burst each (INCR, FIXED, WRAP), perform the beats against the SRAM, and return R/B responses with echoed IDs. Out-of-window beats get SLVERR. The block is the bring-up and test target that sits in place of DDR.

## Interface
- BASE, 32'h1000_0000: byte address of SRAM word 0; must be aligned to DEPTH*8.
- DEPTH, 1024: number of 64-bit words, power of two ≥ 2.
- clock  in  1  sole clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high.
- s_axi_awid/awaddr/awlen/awsize/awburst  in  8/32/8/3/2  write address; awlock(1), awcache(4), awprot(3), awqos(4) inputs, ignored.
- s_axi_awvalid in 1 / s_axi_awready out 1  AW handshake.
- s_axi_wdata/wstrb/wlast/wvalid  in  64/8/1/1; s_axi_wready  out  1.
- s_axi_bid/bresp/bvalid  out  8/2/1; s_axi_bready  in  1.
- s_axi_arid/araddr/arlen/arsize/arburst  in  8/32/8/3/2  read address; arlock/arcache/arprot/arqos inputs, ignored.
- s_axi_arvalid in 1 / s_axi_arready out 1  AR handshake.
- s_axi_rid/rdata/rresp/rlast/rvalid  out  8/64/2/1/1; s_axi_rready  in  1.

## Operation
- Write FSM W_IDLE → W_DATA → W_RESP → W_IDLE.
  - W_IDLE: awready=1. On AW handshake, latch id, addr, len, size, burst, clear the error flag, and go to W_DATA.
  - W_DATA: wready=1. Each W handshake writes wdata to word (addr−BASE)>>3, byte lanes gated by wstrb, if the beat address is in [BASE, BASE+DEPTH*8). Otherwise nothing is written and the error flag sets (sticky). Then advance the address. The beat handshake with wlast=1, or the (len+1)th beat, goes to W_RESP. Beats past len+1 never occur; a wlast arriving early also ends the burst.
  - W_RESP: bvalid=1, bid=latched id, bresp=2'b10 if the error flag is set, else 2'b00. Hold until bready, then return to W_IDLE.
- Read FSM R_IDLE → R_FETCH → R_DATA.
  - R_IDLE: arready=1. On AR handshake, latch fields and go to R_FETCH.
  - R_FETCH: one cycle; SRAM read at the current beat word.
  - R_DATA: rvalid=1 with rdata, rid, rlast (=beat count==len), rresp. An out-of-window beat gives rdata=0, rresp=2'b10; otherwise 2'b00. On R handshake: if rlast, go to R_IDLE; else advance the address and go to R_FETCH.
- Address advance (inc = 1<<size):
  - FIXED: address unchanged.
  - INCR: addr + inc, 32-bit wrap.
  - WRAP with len ∈ {1,3,7,15}: bound = (len+1)*inc; addr = (addr & ~(bound−1)) | ((addr+inc) & (bound−1)).
  - WRAP with any other len behaves as INCR.
  - burst 2'b11 behaves as INCR.
- Narrow sizes: word select is always addr>>3; lane selection is left to the master's wstrb and the master's rdata lane pick.
- Read and write engines run concurrently. Same-word read and write in the same cycle: the read returns the old data (read-first).

## Timing
- Reset values: awready=1, arready=1, wready=0, bvalid=0, rvalid=0, bid=0, bresp=0, rid=0, rdata=0, rresp=0, rlast=0. SRAM contents are not reset.
- Reset mid-burst drops the transaction, returns both FSMs to IDLE, and emits no response. SRAM writes completed before reset persist.
- awready is high only in W_IDLE; arready is high only in R_IDLE. One outstanding burst per direction.
- Write: AW handshake in cycle t; first wready in t+1; with zero W stalls the last beat is in t+len+1 and bvalid is in t+len+2.
- Read: AR handshake in t; R_FETCH in t+1; first rvalid in t+2. With rready held high a beat issues every 2 cycles; the last beat is at t+2+2*len.
- Outputs stay stable while valid is high and ready is low. No output depends combinationally on any input.

## Test plan
- Reset: assert reset for 3 cycles, mid-burst → all outputs at reset values; the next AW is accepted in the first cycle after reset deasserts.
- INCR write then read: write awaddr=0x1000_0000, len=3, size=3, data 0x11..0x44, wstrb=0xFF, bready=1 → bresp=0 and bid echoed. Then read the same range → rdata 0x11,0x22,0x33,0x44, rlast only on beat 4, rvalid in cycles t+2, t+4, t+6, t+8.
- WRAP: araddr=0x1000_0018, len=3, size=3 after the prior write → word order 3,0,1,2 (0x44,0x11,0x22,0x33).
- Out of window: awaddr=0x1000_1FF8 (DEPTH=1024), len=1 INCR → beat 0 written, beat 1 dropped, bresp=2'b10; a read of 0x1000_2000 → rdata=0, rresp=2'b10.
- Backpressure and strobes: wvalid toggled each cycle with wstrb=0x0F, then rready low for 5 cycles → partial bytes merge correctly; rvalid, rdata, rid held stable through the stall.
- Concurrency: AW and AR to the same word in the same cycle → the read returns pre-write data, both responses carry correct IDs, and a subsequent read returns the new data.
